// File: rtl/alu_ctrl_seq_if.sv
// Decode/handshake bundle between the EX-stage pipeline and alu_ctrl_seq.
// The pipeline side uses the master modport, the controller uses slave.
interface alu_ctrl_seq_if #(
  parameter int ALUOP_W = 3,
  parameter int SEL_W   = 4
) ();
  logic               valid_in;
  logic [5:0]         funct;
  logic [ALUOP_W-1:0] aluop;
  logic               stall_in;
  logic [SEL_W-1:0]   select_out;
  logic               valid_out;
  logic               md_start;
  logic [1:0]         md_op;
  logic               stall_out;
  logic               illegal;

  modport master (
    output valid_in, funct, aluop, stall_in,
    input  select_out, valid_out, md_start, md_op, stall_out, illegal
  );

  modport slave (
    input  valid_in, funct, aluop, stall_in,
    output select_out, valid_out, md_start, md_op, stall_out, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with mult/div sequencing for the EX stage.
// Optional sticky illegal-decode trap enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
//
// state   | meaning
// IDLE    | accepting decodes; select_out/valid_out follow accepted ops
// MD_RUN  | mult/div unit busy, counter running down, stall_out high
// MD_DONE | md writeback select presented until the pipeline takes it
module alu_ctrl_seq #(
  parameter int ALUOP_W    = 3,
  parameter int SEL_W      = 4,
  parameter int MD_LATENCY = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_ALUX = 4'b0011;
  localparam logic [3:0] SEL_MFHI = 4'b0100;
  localparam logic [3:0] SEL_MFLO = 4'b0101;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_SLL  = 4'b1000;
  localparam logic [3:0] SEL_SRL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
  localparam logic [3:0] SEL_NOR  = 4'b1100;
  localparam logic [3:0] SEL_XOR  = 4'b1101;
  localparam logic [3:0] SEL_MDWB = 4'b1110;
  localparam logic [3:0] SEL_SLTU = 4'b1111;

  localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] sel_r, sel_nxt;
  logic       valid_r, valid_nxt;
  logic       md_start_r, md_start_nxt;
  logic [1:0] md_op_r, md_op_nxt;

  logic [7:0] aluop_x;
  logic [3:0] dec_sel;
  logic       dec_illegal;
  logic       dec_md;
  logic       accept;

  // Zero-extend so the legacy 2-bit build shares the same decode table.
  assign aluop_x = 8'(bus.aluop);
  assign accept  = bus.valid_in & ~bus.stall_in & (state == IDLE);

  always_comb begin
    dec_sel     = SEL_ALUX;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    case (aluop_x)
      8'd0: dec_sel = SEL_ADD;
      8'd1: dec_sel = SEL_SUB;
      8'd2: begin
        case (bus.funct)
          6'b100000: dec_sel = SEL_ADD;
          6'b100010: dec_sel = SEL_SUB;
          6'b100100: dec_sel = SEL_AND;
          6'b100101: dec_sel = SEL_OR;
          6'b101010: dec_sel = SEL_SLT;
          6'b100111: dec_sel = SEL_NOR;
          6'b100110: dec_sel = SEL_XOR;
          6'b101011: dec_sel = SEL_SLTU;
          6'b000000: dec_sel = SEL_SLL;
          6'b000010: dec_sel = SEL_SRL;
          6'b000011: dec_sel = SEL_SRA;
          6'b010000: dec_sel = SEL_MFHI;
          6'b010010: dec_sel = SEL_MFLO;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_md = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      8'd3: dec_illegal = 1'b1;
      8'd4: dec_sel = SEL_AND;
      8'd5: dec_sel = SEL_OR;
      8'd6: dec_sel = SEL_SLT;
      8'd7: dec_sel = SEL_SLTU;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_nxt      = sel_r;
    valid_nxt    = valid_r;
    md_start_nxt = 1'b0;
    md_op_nxt    = md_op_r;
    case (state)
      IDLE: begin
        if (!bus.stall_in) begin
          valid_nxt = 1'b0;
          if (bus.valid_in) begin
            if (dec_md) begin
              md_start_nxt = 1'b1;
              md_op_nxt    = bus.funct[1:0];
              cnt_nxt      = CNT_LOAD;
              state_nxt    = MD_RUN;
            end else begin
              sel_nxt   = dec_sel;
              valid_nxt = 1'b1;
            end
          end
        end
      end
      MD_RUN: begin
        // The unit runs on its own clock budget; downstream stalls cannot pause it.
        if (cnt == 8'd0) begin
          state_nxt = MD_DONE;
          sel_nxt   = SEL_MDWB;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      MD_DONE: begin
        if (!bus.stall_in) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      sel_r      <= 4'd0;
      valid_r    <= 1'b0;
      md_start_r <= 1'b0;
      md_op_r    <= 2'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_r      <= sel_nxt;
      valid_r    <= valid_nxt;
      md_start_r <= md_start_nxt;
      md_op_r    <= md_op_nxt;
    end
  end

  assign bus.select_out = SEL_W'(sel_r);
  assign bus.valid_out  = valid_r;
  assign bus.md_start   = md_start_r;
  assign bus.md_op      = md_op_r;
  assign bus.stall_out  = (state == MD_RUN);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky until reset so exception logic can sample it late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_r <= 1'b1;
    end
  end

  assign bus.illegal = illegal_r;
`else
  logic unused_trap;

  assign unused_trap = accept ^ dec_illegal;
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: directed test-plan cases then random traffic,
// checked against a table-driven reference model of the decode and mult/div timing.
module tb_alu_ctrl_seq;
  localparam int ALUOP_W = 3;
  localparam int SEL_W   = 4;
  localparam int MD_LAT  = 4;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.ALUOP_W(ALUOP_W), .SEL_W(SEL_W)) bus ();

  alu_ctrl_seq #(.ALUOP_W(ALUOP_W), .SEL_W(SEL_W), .MD_LATENCY(MD_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] sel;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  logic [3:0] aluop_tbl[8];
  logic [3:0] rtype_tbl[logic [5:0]];
  logic [5:0] funct_pool[18];

  // Reference model state: 0 idle, 1 unit running, 2 writeback presented
  int         phase = 0;
  int         left = 0;
  bit         exp_valid = 0, exp_stall = 0, exp_md_start = 0, sticky = 0;
  logic [1:0] exp_md_op = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_decode(input int op, input logic [5:0] f,
                                     output logic [3:0] sel, output logic ill, output logic md);
    sel = 4'd0; ill = 1'b0; md = 1'b0;
    if (op == 2) begin
      if (f >= 6'd24 && f <= 6'd27) md = 1'b1;
      else if (rtype_tbl.exists(f)) sel = rtype_tbl[f];
      else begin sel = 4'b0011; ill = 1'b1; end
    end else begin
      sel = aluop_tbl[op];
      ill = (op == 3);
    end
  endfunction

  // Called at posedge+1; applies inputs, lets one edge pass, advances the model.
  task automatic drive(input bit v, input int op, input logic [5:0] f, input bit st);
    logic [SEL_W-1:0] pre_sel;
    logic             pre_valid;
    logic [1:0]       pre_mdop;
    int               pre_phase;
    logic [3:0]       sel;
    logic             ill, md;
    exp_t             e;
    pre_sel = bus.select_out; pre_valid = bus.valid_out; pre_mdop = bus.md_op;
    pre_phase = phase;
    bus.valid_in = v; bus.aluop = ALUOP_W'(op); bus.funct = f; bus.stall_in = st;
    @(posedge clk); #1;
    exp_md_start = 0;
    case (pre_phase)
      0: begin
        if (v && !st) begin
          ref_decode(op, f, sel, ill, md);
          if (ill && TRAP_EN) sticky = 1;
          if (md) begin
            phase = 1; left = MD_LAT; exp_md_start = 1; exp_md_op = f[1:0]; exp_valid = 0;
            e.sel = 4'b1110;
          end else begin
            exp_valid = 1;
            e.sel = sel;
          end
          e.ill = sticky;
          sb.push_back(e);
        end else if (!st) begin
          exp_valid = 0;
        end
      end
      1: begin
        left--;
        if (left == 0) begin phase = 2; exp_valid = 1; end
      end
      default: if (!st) begin phase = 0; exp_valid = 0; end
    endcase
    exp_stall = (phase == 1);
    if (st && pre_phase != 1) begin
      check("hold_select", 32'(bus.select_out), 32'(pre_sel));
      check("hold_valid", 32'(bus.valid_out), 32'(pre_valid));
    end
    if (st) check("hold_md_op", 32'(bus.md_op), 32'(pre_mdop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 6'd0, 0);
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks outputs clear at once.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_select", 32'(bus.select_out), 0);
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_md_start", 32'(bus.md_start), 0);
    check("rst_md_op", 32'(bus.md_op), 0);
    check("rst_stall", 32'(bus.stall_out), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    phase = 0; left = 0; exp_valid = 0; exp_stall = 0; exp_md_start = 0; exp_md_op = 0;
    sticky = 0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle status checks, scoreboard pop whenever an output is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid_out", 32'(bus.valid_out), 32'(exp_valid));
        check("stall_out", 32'(bus.stall_out), 32'(exp_stall));
        check("md_start", 32'(bus.md_start), 32'(exp_md_start));
        if (exp_stall) check("md_op", 32'(bus.md_op), 32'(exp_md_op));
        if (bus.valid_out && !bus.stall_in) begin
          if (sb.size() == 0) begin
            check("sb_unexpected", 32'(bus.select_out), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("select_out", 32'(bus.select_out), 32'(e.sel));
            check("illegal", 32'(bus.illegal), 32'(e.ill));
          end
        end
      end
    end
  end

  initial begin
    aluop_tbl = '{4'b0010, 4'b0110, 4'b0000, 4'b0011, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
    rtype_tbl[6'b100000] = 4'b0010; rtype_tbl[6'b100010] = 4'b0110;
    rtype_tbl[6'b100100] = 4'b0000; rtype_tbl[6'b100101] = 4'b0001;
    rtype_tbl[6'b101010] = 4'b0111; rtype_tbl[6'b100111] = 4'b1100;
    rtype_tbl[6'b100110] = 4'b1101; rtype_tbl[6'b101011] = 4'b1111;
    rtype_tbl[6'b000000] = 4'b1000; rtype_tbl[6'b000010] = 4'b1001;
    rtype_tbl[6'b000011] = 4'b1010; rtype_tbl[6'b010000] = 4'b0100;
    rtype_tbl[6'b010010] = 4'b0101;
    funct_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111,
                   6'b100110, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b010000,
                   6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b111111};

    bus.valid_in = 0; bus.aluop = '0; bus.funct = '0; bus.stall_in = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_select", 32'(bus.select_out), 0);
    check("reset_valid", 32'(bus.valid_out), 0);
    check("reset_stall", 32'(bus.stall_out), 0);

    drive(1, 2, 6'b100010, 0);
    drive(1, 0, 6'b000000, 0);
    drive(1, 1, 6'b000000, 0);
    drive(1, 2, 6'b000011, 0);
    drive(1, 7, 6'b000000, 0);
    drive(1, 2, 6'b111111, 0);
    drive(1, 2, 6'b100000, 0);
    drive(1, 3, 6'b100000, 0);
    drive(1, 5, 6'b000000, 0);
    repeat (3) drive(0, 0, 6'd0, 1);
    idle(2);

    drive(1, 2, 6'b011000, 0);
    repeat (6) drive(1, 2, 6'b100000, 0);
    idle(2);

    drive(1, 2, 6'b011011, 0);
    repeat (3) drive(0, 0, 6'd0, 0);
    repeat (4) drive(0, 0, 6'd0, 1);
    idle(3);

    drive(1, 6, 6'd0, 0);
    drive(1, 2, 6'b011011, 0);
    drive(0, 0, 6'd0, 0);
    mid_reset();
    idle(8);

    for (int i = 0; i < 600; i++) begin
      bit         v, st;
      int         op;
      logic [5:0] f;
      v  = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 3) == 0);
      op = (($urandom_range(0, 1) == 0) ? 2 : int'($urandom_range(0, 7)));
      f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 17)];
      drive(v, op, f, st);
    end

    idle(MD_LAT + 6);
    check("sb_drain", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the combinational ALU control decoder in the EX stage of the MIPS pipeline.
- Decodes aluop/funct into a widened ALU select. Adds immediate-op aluop codes and shift/nor/xor/sltu functs.
- Sequences multicycle mult/div ops, stalling the pipeline through a busy handshake until the multiply/divide unit finishes.

Parameters:
- ALUOP_W, 3, aluop width; 2 gives legacy four codes only (lwsw, beq, Rtype, unknown), 3 adds immediate codes.
- SEL_W, 4, select width; minimum 4; codes zero-extended into upper bits when wider.
- MD_LATENCY, 32, cycles the mult/div unit runs after md_start; legal range 2..255.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  decode inputs valid this cycle
- funct  in  6  instruction funct field
- aluop  in  ALUOP_W  main-control ALU op class
- stall_in  in  1  downstream hold; freezes registered outputs
- select_out  out  SEL_W  registered ALU select
- valid_out  out  1  select_out valid for EX this cycle
- md_start  out  1  one-cycle pulse launching the mult/div unit
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; held while busy
- stall_out  out  1  to hazard unit; high while mult/div in progress
- illegal  out  1  see Optional Feature

Behaviour:
- Reset (async, rst_n low): select_out=0, valid_out=0, md_start=0, md_op=0, stall_out=0, illegal=0, state=IDLE, counter=0. Reset mid-mult/div aborts the op; no md_start is reissued.
- Accept condition: accept = valid_in & ~stall_in & (state==IDLE). All decode results register on the clock edge; latency is 1 cycle from accept to valid_out.
- aluop decode:
  - 000 lwsw -> add 0010
  - 001 beq -> sub 0110
  - 010 Rtype -> funct decode
  - 011 unknown -> ALUx 0011
  - 100 andi -> 0000
  - 101 ori -> 0001
  - 110 slti -> 0111
  - 111 sltiu -> 1111
- Rtype funct decode:
  - 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111
  - 100111 nor 1100; 100110 xor 1101; 101011 sltu 1111
  - 000000 sll 1000; 000010 srl 1001; 000011 sra 1010
  - 010000 mfhi 0100; 010010 mflo 0101
  - any other funct -> ALUx 0011
- No accept with stall_in low and valid_in low: valid_out=0, select_out holds its last value.
- stall_in high: select_out, valid_out and md_op all hold.
- Mult/div (Rtype with funct 011000/011001/011010/011011):
  - on accept: md_start=1 for one cycle, md_op set, counter=MD_LATENCY-1, state IDLE->MD_RUN; valid_out=0 that cycle.
  - MD_RUN: stall_out=1; counter decrements each cycle regardless of stall_in; valid_in ignored (upstream must hold). At counter==0 -> MD_DONE.
  - MD_DONE: stall_out=0, valid_out=1, select_out=1110 (md writeback). If stall_in low -> IDLE next cycle; if stall_in high, remain in MD_DONE.
- Mult/div with stall_in high is not accepted until stall_in drops.
- valid_in with a normal op is never accepted in the same cycle a mult/div is in MD_RUN or MD_DONE.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - illegal is registered with the accept and asserts with valid_out whenever select_out==0011 results from an unmatched Rtype funct or aluop 011.
  - A sticky internal flag holds illegal high until reset, so it remains visible to the exception logic.
- Undefined:
  - illegal is tied to 0 and no flag exists.
  - Unmatched decodes still produce ALUx 0011, giving an all-X ALU result.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Legacy decode: aluop=010, funct=100010, valid_in=1 -> next cycle select_out=0110, valid_out=1. aluop=000 -> 0010. aluop=001 -> 0110.
- New ops: aluop=010, funct=000011 -> 1010. aluop=111 -> 1111. aluop=010, funct=111111 -> 0011 (with ALU_CTRL_ILLEGAL_TRAP_EN, illegal=1 and stays 1 after a following add).
- Mult with MD_LATENCY=4: funct=011000 accept -> md_start pulse, md_op=00. stall_out=1 for exactly 4 cycles, then one cycle valid_out=1 with select_out=1110. A valid_in add during the stall is not accepted.
- stall_in: assert stall_in for 3 cycles after an or decode -> select_out=0001 held, valid_out held. In MD_DONE with stall_in=1 -> the state persists until stall_in=0.
- Reset mid-op: rst_n low in MD_RUN at counter=2 -> IDLE, stall_out=0, no valid_out pulse afterward.
